// File: rtl/imem_arb_if.sv
// Host/core instruction-memory access bus.
//   Host side : h_req, h_we, h_addr, h_wdata -> h_gnt, h_rvalid, h_rdata
//   Core side : c_req, c_addr               -> c_gnt, c_rvalid, c_rdata
// The master modport is the requester side; the slave modport is the arbiter.
interface imem_arb_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
);
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic          c_req;
  logic [AW-1:0] c_addr;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  modport master (
    output h_req, h_we, h_addr, h_wdata, c_req, c_addr,
    input  h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata
  );

  modport slave (
    input  h_req, h_we, h_addr, h_wdata, c_req, c_addr,
    output h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata
  );
endinterface

// File: rtl/imem_arb.sv
// Single-port instruction memory shared by a host (read/write) and a core
// (fetch only). Simultaneous requests alternate round-robin; the host wins
// the first conflict after reset.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - imem_arb_if.slave: host/core request, combinational grant,
//               registered read-data return
//   conflicts - saturating count of cycles with both requests asserted
module imem_arb #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_arb_if.slave    bus,
  output logic [7:0]   conflicts
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = 8;
  localparam logic [CW-1:0] CMAX = CW'(255);

  typedef enum logic {
    WIN_HOST = 1'b0,
    WIN_CORE = 1'b1
  } winner_e;

  winner_e       last_win;
  logic [DW-1:0] mem [DEPTH];

  logic          host_sel_c;
  logic          h_gnt_c;
  logic          c_gnt_c;
  logic          both_req_c;
  logic [AW-1:0] acc_addr_c;
  logic [DW-1:0] acc_rdata_c;

  logic          h_rvalid;
  logic          c_rvalid;
  logic [DW-1:0] h_rdata;
  logic [DW-1:0] c_rdata;

  // Arbitration and the single shared memory port
  always_comb begin
    both_req_c  = bus.h_req & bus.c_req;
    host_sel_c  = bus.h_req & (~bus.c_req | (last_win == WIN_CORE));
    // Grants are suppressed while reset is held
    h_gnt_c     = rst_n & host_sel_c;
    c_gnt_c     = rst_n & bus.c_req & ~host_sel_c;
    acc_addr_c  = h_gnt_c ? bus.h_addr : bus.c_addr;
    acc_rdata_c = mem[acc_addr_c];
  end

  assign bus.h_gnt    = h_gnt_c;
  assign bus.c_gnt    = c_gnt_c;
  assign bus.h_rvalid = h_rvalid;
  assign bus.c_rvalid = c_rvalid;
  assign bus.h_rdata  = h_rdata;
  assign bus.c_rdata  = c_rdata;

  // Memory array: contents survive reset
  always_ff @(posedge clk) begin
    if (h_gnt_c && bus.h_we) begin
      mem[acc_addr_c] <= bus.h_wdata;
    end
  end

  // Arbitration history, read return and conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win  <= WIN_CORE;
      h_rvalid  <= 1'b0;
      c_rvalid  <= 1'b0;
      h_rdata   <= '0;
      c_rdata   <= '0;
      conflicts <= '0;
    end else begin
      if (h_gnt_c) begin
        last_win <= WIN_HOST;
      end else if (c_gnt_c) begin
        last_win <= WIN_CORE;
      end

      h_rvalid <= h_gnt_c & ~bus.h_we;
      c_rvalid <= c_gnt_c;

      // rdata only moves on a granted read, otherwise holds
      if (h_gnt_c && !bus.h_we) begin
        h_rdata <= acc_rdata_c;
      end
      if (c_gnt_c) begin
        c_rdata <= acc_rdata_c;
      end

      if (both_req_c && (conflicts != CMAX)) begin
        conflicts <= conflicts + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: stimulus pushes expected read data when a
// read grant is expected; a negedge monitor pops and compares on each rvalid.
module tb_imem_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] conflicts;

  imem_arb_if #(.AW(5), .DW(8)) bus ();

  imem_arb #(.AW(5), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .conflicts (conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] hq[$];
  logic [7:0] cq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  // Monitor: every rvalid must match the oldest expected read
  always @(negedge clk) begin
    if (bus.h_rvalid === 1'b1) begin
      if (hq.size() == 0) chk("h_rvalid_unexpected", 32'd1, 32'd0);
      else chk("h_rdata", {24'd0, bus.h_rdata}, {24'd0, hq.pop_front()});
    end
    if (bus.c_rvalid === 1'b1) begin
      if (cq.size() == 0) chk("c_rvalid_unexpected", 32'd1, 32'd0);
      else chk("c_rdata", {24'd0, bus.c_rdata}, {24'd0, cq.pop_front()});
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic cyc(input logic hr, input logic hw, input logic [4:0] ha,
                     input logic [7:0] hd, input logic cr, input logic [4:0] ca,
                     input logic eh, input logic ec, input logic [7:0] ed,
                     input string nm);
    bus.h_req   = hr;
    bus.h_we    = hw;
    bus.h_addr  = ha;
    bus.h_wdata = hd;
    bus.c_req   = cr;
    bus.c_addr  = ca;
    if (eh && !hw) hq.push_back(ed);
    if (ec) cq.push_back(ed);
    @(negedge clk);
    chk({nm, "_h_gnt"}, {31'd0, bus.h_gnt}, {31'd0, eh});
    chk({nm, "_c_gnt"}, {31'd0, bus.c_gnt}, {31'd0, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    cyc(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, nm);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.h_req   = 1'b0;
    bus.h_we    = 1'b0;
    bus.h_addr  = '0;
    bus.h_wdata = '0;
    bus.c_req   = 1'b0;
    bus.c_addr  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_h_rvalid", {31'd0, bus.h_rvalid}, 32'd0);
    chk("rst_c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("rst_h_rdata", {24'd0, bus.h_rdata}, 32'd0);
    chk("rst_c_rdata", {24'd0, bus.c_rdata}, 32'd0);
    chk("rst_conflicts", {24'd0, conflicts}, 32'd0);
    bus.h_req = 1'b1;
    bus.c_req = 1'b1;
    #1;
    chk("rst_h_gnt", {31'd0, bus.h_gnt}, 32'd0);
    chk("rst_c_gnt", {31'd0, bus.c_gnt}, 32'd0);
    bus.h_req = 1'b0;
    bus.c_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Host write/write/read-back, plus preload of a few words
    cyc(1, 1, 5'd0,  8'h01, 0, 5'd0, 1, 0, 8'h00, "hw0");
    cyc(1, 1, 5'd1,  8'h05, 0, 5'd0, 1, 0, 8'h00, "hw1");
    cyc(1, 0, 5'd1,  8'h00, 0, 5'd0, 1, 0, 8'h05, "hr1");
    cyc(1, 1, 5'd31, 8'h3C, 0, 5'd0, 1, 0, 8'h00, "hw31");
    cyc(1, 1, 5'd2,  8'h22, 0, 5'd0, 1, 0, 8'h00, "hw2");
    idle("idle_a");
    @(negedge clk);
    chk("h_rdata_hold", {24'd0, bus.h_rdata}, 32'h05);
    @(posedge clk);
    #1;

    // Write then core read of the same address on the next cycle
    cyc(1, 1, 5'd3, 8'hAA, 0, 5'd0, 1, 0, 8'h00, "hw3");
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd3, 0, 1, 8'hAA, "cr3");

    // Core-only reads wrapping 31 -> 0 back to back
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd31, 0, 1, 8'h3C, "cr31");
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd0,  0, 1, 8'h01, "cr0");
    idle("idle_b");
    idle("idle_c");

    // Reset pulse: rdata cleared, memory retained
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_h_rdata", {24'd0, bus.h_rdata}, 32'd0);
    chk("rst2_c_rdata", {24'd0, bus.c_rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention from reset: host, core, host, core
    cyc(1, 0, 5'd1, 8'h00, 1, 5'd2, 1, 0, 8'h05, "rr1");
    cyc(1, 0, 5'd1, 8'h00, 1, 5'd2, 0, 1, 8'h22, "rr2");
    cyc(1, 0, 5'd1, 8'h00, 1, 5'd2, 1, 0, 8'h05, "rr3");
    cyc(1, 0, 5'd1, 8'h00, 1, 5'd2, 0, 1, 8'h22, "rr4");
    idle("idle_d");
    @(negedge clk);
    chk("conflicts_4", {24'd0, conflicts}, 32'd4);
    @(posedge clk);
    #1;

    // Core read granted, then reset before the next edge drops it
    bus.c_req  = 1'b1;
    bus.c_addr = 5'd3;
    @(negedge clk);
    chk("mid_c_gnt", {31'd0, bus.c_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_c_rvalid", {31'd0, bus.c_rvalid}, 32'd0);
    chk("mid_c_rdata", {24'd0, bus.c_rdata}, 32'd0);
    chk("mid_h_rdata", {24'd0, bus.h_rdata}, 32'd0);
    chk("mid_conflicts", {24'd0, conflicts}, 32'd0);
    chk("mid_c_gnt_rst", {31'd0, bus.c_gnt}, 32'd0);
    bus.c_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_c_rvalid_edge", {31'd0, bus.c_rvalid}, 32'd0);
    rst_n = 1'b1;
    idle("idle_e");
    idle("idle_f");
    cyc(0, 0, 5'd0, 8'h00, 1, 5'd3, 0, 1, 8'hAA, "cr3_retain");

    // Long contention: strict alternation and counter saturation
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)
        cyc(1, 0, 5'd0, 8'h00, 1, 5'd31, 1, 0, 8'h01, "sat");
      else
        cyc(1, 0, 5'd0, 8'h00, 1, 5'd31, 0, 1, 8'h3C, "sat");
    end
    idle("idle_g");
    @(negedge clk);
    chk("conflicts_sat", {24'd0, conflicts}, 32'd255);
    @(posedge clk);
    #1;
    idle("idle_h");
    idle("idle_i");
    chk("hq_drained", hq.size(), 32'd0);
    chk("cq_drained", cq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
